// File: rtl/hd44780_bus_monitor_if.sv
// Bundle of the HD44780 4-bit LCD bus plus the monitor's status/readback signals.
// err_timing exists only when HD44780_MON_TIMING_CHECK_EN is defined.
interface hd44780_bus_monitor_if;
    logic       lcd_rs;
    logic       lcd_e;
    logic [3:0] lcd_d;
    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_data;
    logic       four_bit_mode;
    logic       display_on;
    logic [6:0] cursor_addr;
    logic       busy;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_clr;
    logic       err_overrun;
    logic       err_framing;
`ifdef HD44780_MON_TIMING_CHECK_EN
    logic       err_timing;
`endif

    // Bus driver / debug host side
    modport master (
        output lcd_rs, lcd_e, lcd_d, rd_addr, err_clr,
        input  byte_valid, byte_rs, byte_data, four_bit_mode, display_on,
               cursor_addr, busy, rd_data, err_overrun, err_framing
`ifdef HD44780_MON_TIMING_CHECK_EN
        , input err_timing
`endif
    );

    // Monitor side
    modport slave (
        input  lcd_rs, lcd_e, lcd_d, rd_addr, err_clr,
        output byte_valid, byte_rs, byte_data, four_bit_mode, display_on,
               cursor_addr, busy, rd_data, err_overrun, err_framing
`ifdef HD44780_MON_TIMING_CHECK_EN
        , output err_timing
`endif
    );
endinterface

// File: rtl/hd44780_bus_monitor.sv
// HD44780 4-bit bus monitor: nibble reassembly, init handshake, instruction decode, 2-line DDRAM shadow.
// Optional E-high width check enabled by defining HD44780_MON_TIMING_CHECK_EN.
module hd44780_bus_monitor #(
    parameter int unsigned LINE_LEN   = 16
`ifdef HD44780_MON_TIMING_CHECK_EN
    , parameter int unsigned MIN_E_HIGH = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    hd44780_bus_monitor_if.slave  bus
);
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned RAM_AW    = 5;
    localparam int unsigned RAM_DEPTH = 32;
    localparam logic [7:0]  BLANK     = 8'h20;

    typedef enum logic [1:0] {
        IDLE8 = 2'd0,
        HI4   = 2'd1,
        LO4   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       rs_sync, e_sync;
    logic [2:0][3:0]  d_sync;

    logic             byte_valid_q, byte_rs_q, four_bit_q, display_on_q, busy_q, id_inc_q;
    logic [7:0]       byte_data_q, rd_data_q;
    logic [ADDR_W-1:0] cursor_q;
    logic [3:0]       hi_nib_q;
    logic             hi_rs_q;
    logic [RAM_AW-1:0] clr_idx_q;
    logic             err_overrun_q, err_framing_q;

    logic [7:0]       shadow [RAM_DEPTH];

    logic             strobe_c, rs_cur_c;
    logic             store_hi_c, byte_done_c, lo_phase_c;
    logic [7:0]       asm_byte_c;
    logic             accept_c, fn_set_c, clear_c, in_window_c;
    logic             ram_we_c;
    logic [RAM_AW-1:0] ram_wa_c;
    logic [7:0]       ram_wd_c;

    // Two-flop synchronisers plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_sync <= '0;
            e_sync  <= '0;
            d_sync  <= '0;
        end else begin
            rs_sync <= {rs_sync[1:0], bus.lcd_rs};
            e_sync  <= {e_sync[1:0], bus.lcd_e};
            d_sync  <= {d_sync[1:0], bus.lcd_d};
        end
    end

    assign strobe_c = e_sync[2] & ~e_sync[1];
    assign rs_cur_c = rs_sync[2];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE8;
        else     state_q <= state_d;
    end

    // FSM outputs: what a strobe means in the current nibble phase
    always_comb begin
        store_hi_c  = 1'b0;
        byte_done_c = 1'b0;
        lo_phase_c  = 1'b0;
        asm_byte_c  = {d_sync[2], 4'h0};
        case (state_q)
            IDLE8: byte_done_c = strobe_c;
            HI4:   store_hi_c  = strobe_c;
            LO4: begin
                byte_done_c = strobe_c;
                lo_phase_c  = 1'b1;
                asm_byte_c  = {hi_nib_q, d_sync[2]};
            end
            default: ;
        endcase
    end

    assign accept_c    = byte_done_c & ~busy_q;
    assign fn_set_c    = accept_c & ~rs_cur_c & (asm_byte_c[7:5] == 3'b001);
    // Clear is honoured even while busy so that a repeated Clear restarts the fill
    assign clear_c     = byte_done_c & ~rs_cur_c & (asm_byte_c == 8'h01);
    assign in_window_c = 32'(cursor_q[5:0]) < LINE_LEN;

    // FSM next state; Function Set re-syncs the nibble phase to HIGH
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE8: ;
            HI4:   if (strobe_c) state_d = LO4;
            LO4:   if (strobe_c) state_d = HI4;
            default: state_d = IDLE8;
        endcase
        if (fn_set_c) state_d = asm_byte_c[4] ? IDLE8 : HI4;
    end

    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a, input logic inc);
        logic [ADDR_W-1:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // Byte output, nibble holding, instruction decode, clear sequencer, error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid_q  <= 1'b0;
            byte_rs_q     <= 1'b0;
            byte_data_q   <= '0;
            hi_nib_q      <= '0;
            hi_rs_q       <= 1'b0;
            four_bit_q    <= 1'b0;
            display_on_q  <= 1'b0;
            id_inc_q      <= 1'b1;
            cursor_q      <= '0;
            busy_q        <= 1'b0;
            clr_idx_q     <= '0;
            err_overrun_q <= 1'b0;
            err_framing_q <= 1'b0;
        end else begin
            byte_valid_q <= byte_done_c;
            if (byte_done_c) begin
                byte_rs_q   <= rs_cur_c;
                byte_data_q <= asm_byte_c;
            end
            if (store_hi_c) begin
                hi_nib_q <= d_sync[2];
                hi_rs_q  <= rs_cur_c;
            end

            if (accept_c && !rs_cur_c) begin
                casez (asm_byte_c)
                    8'b1???????: cursor_q     <= asm_byte_c[6:0];
                    8'b01??????: ;
                    8'b001?????: four_bit_q   <= ~asm_byte_c[4];
                    8'b0001????: ;
                    8'b00001???: display_on_q <= asm_byte_c[2];
                    8'b000001??: id_inc_q     <= asm_byte_c[1];
                    8'b0000001?: cursor_q     <= '0;
                    default: ;
                endcase
            end else if (accept_c && rs_cur_c) begin
                cursor_q <= addr_step(cursor_q, id_inc_q);
            end

            if (clear_c) begin
                busy_q    <= 1'b1;
                clr_idx_q <= '0;
                cursor_q  <= '0;
                id_inc_q  <= 1'b1;
            end else if (busy_q) begin
                clr_idx_q <= clr_idx_q + 5'd1;
                if (clr_idx_q == 5'(RAM_DEPTH - 1)) busy_q <= 1'b0;
            end

            if (bus.err_clr) begin
                err_overrun_q <= 1'b0;
                err_framing_q <= 1'b0;
            end else begin
                if (byte_done_c && busy_q) err_overrun_q <= 1'b1;
                if (byte_done_c && lo_phase_c && (rs_cur_c != hi_rs_q)) err_framing_q <= 1'b1;
            end
        end
    end

    // Single shadow write port: clear fill has priority (data writes are blocked while busy)
    always_comb begin
        ram_we_c = 1'b0;
        ram_wa_c = clr_idx_q;
        ram_wd_c = BLANK;
        if (busy_q) begin
            ram_we_c = 1'b1;
        end else if (accept_c && rs_cur_c && in_window_c) begin
            ram_we_c = 1'b1;
            ram_wa_c = {cursor_q[6], cursor_q[3:0]};
            ram_wd_c = asm_byte_c;
        end
    end

    // Shadow contents survive rst
    always_ff @(posedge clk) begin
        if (ram_we_c && !rst) shadow[ram_wa_c] <= ram_wd_c;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= shadow[bus.rd_addr];
    end

`ifdef HD44780_MON_TIMING_CHECK_EN
    logic [7:0] e_high_cnt_q;
    logic       err_timing_q;

    // Counts prior cycles of synchronised E high; width at the strobe is count+1
    always_ff @(posedge clk) begin
        if (rst) begin
            e_high_cnt_q <= '0;
            err_timing_q <= 1'b0;
        end else begin
            if (!e_sync[2])               e_high_cnt_q <= '0;
            else if (e_high_cnt_q != 8'hFF) e_high_cnt_q <= e_high_cnt_q + 8'd1;

            if (bus.err_clr)
                err_timing_q <= 1'b0;
            else if (strobe_c && (32'(e_high_cnt_q) + 32'd1 < MIN_E_HIGH))
                err_timing_q <= 1'b1;
        end
    end

    assign bus.err_timing = err_timing_q;
`endif

    assign bus.byte_valid    = byte_valid_q;
    assign bus.byte_rs       = byte_rs_q;
    assign bus.byte_data     = byte_data_q;
    assign bus.four_bit_mode = four_bit_q;
    assign bus.display_on    = display_on_q;
    assign bus.cursor_addr   = cursor_q;
    assign bus.busy          = busy_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.err_overrun   = err_overrun_q;
    assign bus.err_framing   = err_framing_q;
endmodule
